// File: rtl/mult_result_stage_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared types for the multiplier result stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int WIDTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             n;
    } mult_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic mult_entry_t make_entry(input logic [WIDTH-1:0] value);
        mult_entry_t e;
        e.res = value;
        e.z   = (value == '0);
        e.n   = value[WIDTH-1];
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_result_stage_if.sv
// ============================================================================
// Module      : mult_result_stage_if
// Description : Upstream/downstream handshake bundle for mult_result_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_result_stage_if
    import mult_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_res;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic             out_z;
    logic             out_n;
    logic             cnt_clr;
    logic [CNT_W-1:0] res_count;

    modport master (
        output in_valid, in_res, out_ready, cnt_clr,
        input  in_ready, out_valid, out_res, out_z, out_n, res_count
    );

    modport slave (
        input  in_valid, in_res, out_ready, cnt_clr,
        output in_ready, out_valid, out_res, out_z, out_n, res_count
    );
endinterface

`default_nettype wire

// File: rtl/mult_result_stage_skid.sv
// ============================================================================
// Module      : skid_buffer_2
// Description : 2-entry valid/ready skid buffer with fully registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_buffer_2
    import mult_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_up_valid,
    output logic             o_up_ready,
    input  wire mult_entry_t i_up_data,
    output logic             o_dn_valid,
    input  wire logic        i_dn_ready,
    output mult_entry_t      o_dn_data
);

    state_t      r_state;
    state_t      w_state_nxt;
    mult_entry_t r_main;
    mult_entry_t r_skid;
    logic        r_up_ready;
    logic        r_dn_valid;

    logic w_accept;
    logic w_deliver;
    logic w_load_main;
    logic w_main_from_skid;
    logic w_load_skid;

    assign w_accept  = i_up_valid & r_up_ready;
    assign w_deliver = r_dn_valid & i_dn_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ONE;
                    w_load_main = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_deliver) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = FULL;
                    w_load_skid = 1'b1;
                end else if (w_deliver) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_deliver) begin
                    w_state_nxt      = ONE;
                    w_load_main      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Ready/valid are re-registered from the next state so neither output
    // depends combinationally on the opposite side of the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_up_ready <= 1'b1;
            r_dn_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_up_ready <= (w_state_nxt != FULL);
            r_dn_valid <= (w_state_nxt != EMPTY);
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : i_up_data;
            end
            if (w_load_skid) begin
                r_skid <= i_up_data;
            end
        end
    end

    assign o_up_ready = r_up_ready;
    assign o_dn_valid = r_dn_valid;
    assign o_dn_data  = r_main;

endmodule

`default_nettype wire

// File: rtl/mult_result_stage.sv
// ============================================================================
// Module      : mult_result_stage
// Description : Registered multiplier output stage with flags and result count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_result_stage
    import mult_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    mult_result_stage_if.slave  bus
);

    mult_entry_t      w_in_entry;
    mult_entry_t      w_out_entry;
    logic             w_out_valid;
    logic             w_deliver;
    logic [CNT_W-1:0] r_count;

    // Flags are computed before capture so they travel with their product.
    assign w_in_entry = make_entry(bus.in_res);

    skid_buffer_2 u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_up_valid (bus.in_valid),
        .o_up_ready (bus.in_ready),
        .i_up_data  (w_in_entry),
        .o_dn_valid (w_out_valid),
        .i_dn_ready (bus.out_ready),
        .o_dn_data  (w_out_entry)
    );

    assign w_deliver = w_out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (bus.cnt_clr) begin
            r_count <= '0;
        end else if (w_deliver) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign bus.out_valid = w_out_valid;
    assign bus.out_res   = w_out_entry.res;
    assign bus.out_z     = w_out_entry.z;
    assign bus.out_n     = w_out_entry.n;
    assign bus.res_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mult_result_stage.sv
// ============================================================================
// Module      : tb_mult_result_stage
// Description : Scoreboard bench for mult_result_stage (CNT_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_result_stage;

    localparam int C_CNT_W = 2;

    logic clk;
    logic rst_n;

    mult_result_stage_if #(.CNT_W(C_CNT_W)) bus ();

    mult_result_stage #(.CNT_W(C_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [3:0]         sb_q[$];
    logic [C_CNT_W-1:0] m_cnt;
    int                 n_delivered;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: inputs settle at posedge+1, so the negedge sees
    // exactly the handshake values the next posedge will act on.
    always @(negedge clk) begin
        logic [3:0] v;
        if (!rst_n) begin
            sb_q.delete();
            m_cnt = '0;
        end else begin
            check("res_count", 32'(bus.res_count), 32'(m_cnt));
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 32'(bus.out_res), 32'hFFFF_FFFF);
                end else begin
                    v = sb_q.pop_front();
                    check("out_res", 32'(bus.out_res), 32'(v));
                    check("out_z", 32'(bus.out_z), 32'(v == 4'd0));
                    check("out_n", 32'(bus.out_n), 32'(v[3]));
                end
                n_delivered++;
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(bus.in_res);
            end
            if (bus.cnt_clr) begin
                m_cnt = '0;
            end else if (bus.out_valid && bus.out_ready) begin
                m_cnt = m_cnt + 1'b1;
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_delivered   = 0;
        m_cnt         = '0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_res    = 4'd0;
        bus.out_ready = 1'b0;
        bus.cnt_clr   = 1'b0;
        cyc();
        cyc();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_res", 32'(bus.out_res), 32'd0);
        check("rst_out_z", 32'(bus.out_z), 32'd0);
        check("rst_out_n", 32'(bus.out_n), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_count", 32'(bus.res_count), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single result, latency 1
        bus.in_valid  = 1'b1;
        bus.in_res    = 4'b0101;
        bus.out_ready = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_res", 32'(bus.out_res), 32'd5);
        check("t1_z", 32'(bus.out_z), 32'd0);
        check("t1_n", 32'(bus.out_n), 32'd0);
        cyc();
        check("t1_count", 32'(bus.res_count), 32'd1);
        check("t1_drained", 32'(bus.out_valid), 32'd0);

        // Back-to-back stream 3, 0, 9
        bus.in_valid = 1'b1;
        bus.in_res   = 4'd3;
        cyc();
        check("t2_res3", 32'(bus.out_res), 32'd3);
        bus.in_res = 4'd0;
        cyc();
        check("t2_res0", 32'(bus.out_res), 32'd0);
        check("t2_z0", 32'(bus.out_z), 32'd1);
        bus.in_res = 4'd9;
        cyc();
        check("t2_res9", 32'(bus.out_res), 32'd9);
        check("t2_n9", 32'(bus.out_n), 32'd1);
        check("t2_z9", 32'(bus.out_z), 32'd0);
        bus.in_valid = 1'b0;
        cyc();
        check("t2_drained", 32'(bus.out_valid), 32'd0);

        // Backpressure: 6, 7 fill the stage, 8 held off
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_res    = 4'd6;
        cyc();
        check("t3_ready_one", 32'(bus.in_ready), 32'd1);
        bus.in_res = 4'd7;
        cyc();
        check("t3_ready_full", 32'(bus.in_ready), 32'd0);
        bus.in_res = 4'd8;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t3_hold_ready", 32'(bus.in_ready), 32'd0);
            check("t3_hold_res", 32'(bus.out_res), 32'd6);
        end
        bus.out_ready = 1'b1;
        cyc();
        check("t3_res7", 32'(bus.out_res), 32'd7);
        check("t3_ready_back", 32'(bus.in_ready), 32'd1);
        cyc();
        check("t3_res8", 32'(bus.out_res), 32'd8);
        bus.in_valid = 1'b0;
        cyc();
        check("t3_drained", 32'(bus.out_valid), 32'd0);

        // Counter wrap with a 2-bit count: 1,2,3,0,1
        bus.cnt_clr = 1'b1;
        cyc();
        bus.cnt_clr = 1'b0;
        check("t4_clr", 32'(bus.res_count), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_res   = 4'(i + 10);
            cyc();
            if (i > 0) check("t4_count", 32'(bus.res_count), 32'(i % 4));
        end
        bus.in_valid = 1'b0;
        cyc();
        check("t4_count_last", 32'(bus.res_count), 32'd1);

        // Clear wins over a simultaneous deliver
        bus.in_valid = 1'b1;
        bus.in_res   = 4'd2;
        cyc();
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b1;
        check("t5_valid", 32'(bus.out_valid), 32'd1);
        cyc();
        bus.cnt_clr = 1'b0;
        check("t5_count", 32'(bus.res_count), 32'd0);

        // Random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_res    = 4'($urandom_range(0, 15));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        cyc();
        check("rand_drained", 32'(sb_q.size()), 32'd0);

        // Asynchronous reset while FULL
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_res    = 4'd12;
        cyc();
        bus.in_res = 4'd13;
        cyc();
        bus.in_valid = 1'b0;
        check("t6_full", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(bus.out_valid), 32'd0);
        check("t6_res", 32'(bus.out_res), 32'd0);
        check("t6_ready", 32'(bus.in_ready), 32'd1);
        check("t6_count", 32'(bus.res_count), 32'd0);
        cyc();
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        cyc();
        cyc();
        check("t6_no_replay", 32'(bus.out_valid), 32'd0);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("delivered_any", 32'(n_delivered > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
